// File: rtl/aclock_setter_pkg.sv
// Shared definitions for the alarm-clock setter.
// Holds the FSM state encoding, the edit_field codes, the hour/minute
// maxima (as plain numbers and as BCD digit pairs) and the range checks
// used when a value is preloaded from the clock core.
package aclock_setter_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        T_HOUR = 3'd1,
        T_MIN  = 3'd2,
        A_HOUR = 3'd3,
        A_MIN  = 3'd4,
        LOAD_T = 3'd5,
        LOAD_A = 3'd6,
        STOP   = 3'd7
    } state_e;

    localparam logic [1:0] FIELD_NONE = 2'd0;
    localparam logic [1:0] FIELD_HOUR = 2'd1;
    localparam logic [1:0] FIELD_MIN  = 2'd2;

    localparam int HOUR_MAX = 32'sd23;
    localparam int MIN_MAX  = 32'sd59;

    // BCD form of the maxima, fed to the wrap incrementers
    localparam logic [1:0] HOUR_MAX_HI = 2'd2;
    localparam logic [3:0] HOUR_MAX_LO = 4'd3;
    localparam logic [3:0] MIN_MAX_HI  = 4'd5;
    localparam logic [3:0] MIN_MAX_LO  = 4'd9;

    // True when the hour digit pair is valid BCD and no larger than 23
    function automatic logic hour_ok(input logic [1:0] hi, input logic [3:0] lo);
        return (lo <= 4'd9) && ((int'(hi) * 32'sd10 + int'(lo)) <= HOUR_MAX);
    endfunction

    // True when the minute digit pair is valid BCD and no larger than 59
    function automatic logic min_ok(input logic [3:0] hi, input logic [3:0] lo);
        return (lo <= 4'd9) && ((int'(hi) * 32'sd10 + int'(lo)) <= MIN_MAX);
    endfunction

endpackage

// File: rtl/aclock_setter_bcd_wrap_inc.sv
// bcd_wrap_inc: increments a BCD digit pair by one, wrapping to 00 once
// the programmable maximum pair is reached.
// Ports: hi/lo      - current pair (high digit width HI_W)
//        max_hi/lo  - largest legal value, wraps to 00 after it
//        inc_hi/lo  - incremented pair
module bcd_wrap_inc #(
    parameter int HI_W = 4
) (
    input  logic [HI_W-1:0] hi,
    input  logic [3:0]      lo,
    input  logic [HI_W-1:0] max_hi,
    input  logic [3:0]      max_lo,
    output logic [HI_W-1:0] inc_hi,
    output logic [3:0]      inc_lo
);

    // Wrap at or above max, otherwise carry low digit 9 into the high digit
    always_comb begin
        inc_hi = hi;
        inc_lo = lo;
        if ({hi, lo} >= {max_hi, max_lo}) begin
            inc_hi = {HI_W{1'b0}};
            inc_lo = 4'd0;
        end else if (lo >= 4'd9) begin
            inc_hi = hi + HI_W'(1'b1);
            inc_lo = 4'd0;
        end else begin
            inc_lo = lo + 4'd1;
        end
    end

endmodule

// File: rtl/aclock_setter.sv
// aclock_setter: button-driven time / alarm setter for the clock core.
// Ports: clk, reset (sync, active low); btn_mode/btn_inc/btn_set debounced
//        buttons; H_out*/M_out* current time and Alarm from the clock core;
//        H_in*/M_in* edit value to the core; LD_time/LD_alarm/STOP_al
//        LOAD_HOLD-cycle strobes; AL_ON alarm enable; edit_field blink
//        select (0 none, 1 hours, 2 minutes).
module aclock_setter
    import aclock_setter_pkg::*;
#(
    parameter int LOAD_HOLD = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_set,
    input  logic [1:0] H_out1,
    input  logic [3:0] H_out0,
    input  logic [3:0] M_out1,
    input  logic [3:0] M_out0,
    input  logic       Alarm,
    output logic [1:0] H_in1,
    output logic [3:0] H_in0,
    output logic [3:0] M_in1,
    output logic [3:0] M_in0,
    output logic       LD_time,
    output logic       LD_alarm,
    output logic       AL_ON,
    output logic       STOP_al,
    output logic [1:0] edit_field
);

    localparam int            CW     = $clog2(LOAD_HOLD + 1);
    localparam logic [CW-1:0] HOLD_C = CW'(LOAD_HOLD);

    state_e        state_r;
    logic          mode_hist_r, inc_hist_r, set_hist_r;
    logic          armed_r;
    logic [1:0]    h1_r;
    logic [3:0]    h0_r, m1_r, m0_r;
    logic [1:0]    al_h1_r;
    logic [3:0]    al_h0_r, al_m1_r, al_m0_r;
    logic [CW-1:0] cnt_r;
    logic          ld_time_r, ld_alarm_r, al_on_r, stop_al_r;
    logic [1:0]    edit_field_r;

    logic          set_edge_s, mode_edge_s, inc_edge_s;
    logic [1:0]    hour_inc_hi_s;
    logic [3:0]    hour_inc_lo_s, min_inc_hi_s, min_inc_lo_s;

    // armed_r masks the first cycle after reset so a button already held
    // at release only loads history; priority set > mode > inc.
    assign set_edge_s  = armed_r & btn_set  & ~set_hist_r;
    assign mode_edge_s = armed_r & btn_mode & ~mode_hist_r & ~set_edge_s;
    assign inc_edge_s  = armed_r & btn_inc  & ~inc_hist_r  & ~set_edge_s & ~mode_edge_s;

    bcd_wrap_inc #(.HI_W(2)) u_hour_inc (
        .hi     (h1_r),
        .lo     (h0_r),
        .max_hi (HOUR_MAX_HI),
        .max_lo (HOUR_MAX_LO),
        .inc_hi (hour_inc_hi_s),
        .inc_lo (hour_inc_lo_s)
    );

    bcd_wrap_inc #(.HI_W(4)) u_min_inc (
        .hi     (m1_r),
        .lo     (m0_r),
        .max_hi (MIN_MAX_HI),
        .max_lo (MIN_MAX_LO),
        .inc_hi (min_inc_hi_s),
        .inc_lo (min_inc_lo_s)
    );

    // Setter FSM with button history, edit/alarm registers and strobes
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= IDLE;
            mode_hist_r  <= 1'b0;
            inc_hist_r   <= 1'b0;
            set_hist_r   <= 1'b0;
            armed_r      <= 1'b0;
            h1_r         <= 2'd0;
            h0_r         <= 4'd0;
            m1_r         <= 4'd0;
            m0_r         <= 4'd0;
            al_h1_r      <= 2'd0;
            al_h0_r      <= 4'd0;
            al_m1_r      <= 4'd0;
            al_m0_r      <= 4'd0;
            cnt_r        <= {CW{1'b0}};
            ld_time_r    <= 1'b0;
            ld_alarm_r   <= 1'b0;
            al_on_r      <= 1'b0;
            stop_al_r    <= 1'b0;
            edit_field_r <= FIELD_NONE;
        end else begin
            mode_hist_r <= btn_mode;
            inc_hist_r  <= btn_inc;
            set_hist_r  <= btn_set;
            armed_r     <= 1'b1;
            case (state_r)
                IDLE: begin
                    if (set_edge_s) begin
                        if (Alarm) begin
                            state_r      <= STOP;
                            cnt_r        <= {CW{1'b0}};
                            edit_field_r <= FIELD_NONE;
                        end else begin
                            state_r      <= A_HOUR;
                            h1_r         <= al_h1_r;
                            h0_r         <= al_h0_r;
                            m1_r         <= al_m1_r;
                            m0_r         <= al_m0_r;
                            edit_field_r <= FIELD_HOUR;
                        end
                    end else if (mode_edge_s) begin
                        state_r      <= T_HOUR;
                        edit_field_r <= FIELD_HOUR;
                        // Out-of-range fields from the core start at 00
                        if (hour_ok(H_out1, H_out0)) begin
                            h1_r <= H_out1;
                            h0_r <= H_out0;
                        end else begin
                            h1_r <= 2'd0;
                            h0_r <= 4'd0;
                        end
                        if (min_ok(M_out1, M_out0)) begin
                            m1_r <= M_out1;
                            m0_r <= M_out0;
                        end else begin
                            m1_r <= 4'd0;
                            m0_r <= 4'd0;
                        end
                    end else if (inc_edge_s) begin
                        al_on_r <= ~al_on_r;
                    end
                end
                T_HOUR, A_HOUR: begin
                    if (set_edge_s) begin
                        state_r      <= IDLE;
                        edit_field_r <= FIELD_NONE;
                    end else if (mode_edge_s) begin
                        state_r      <= (state_r == T_HOUR) ? T_MIN : A_MIN;
                        edit_field_r <= FIELD_MIN;
                    end else if (inc_edge_s) begin
                        h1_r <= hour_inc_hi_s;
                        h0_r <= hour_inc_lo_s;
                    end
                end
                T_MIN, A_MIN: begin
                    if (set_edge_s) begin
                        state_r      <= IDLE;
                        edit_field_r <= FIELD_NONE;
                    end else if (mode_edge_s) begin
                        cnt_r        <= {CW{1'b0}};
                        edit_field_r <= FIELD_NONE;
                        if (state_r == T_MIN) begin
                            state_r <= LOAD_T;
                        end else begin
                            state_r <= LOAD_A;
                            al_h1_r <= h1_r;
                            al_h0_r <= h0_r;
                            al_m1_r <= m1_r;
                            al_m0_r <= m0_r;
                        end
                    end else if (inc_edge_s) begin
                        m1_r <= min_inc_hi_s;
                        m0_r <= min_inc_lo_s;
                    end
                end
                LOAD_T, LOAD_A, STOP: begin
                    // Strobe rises the cycle after entry and lasts LOAD_HOLD cycles
                    if (cnt_r == HOLD_C) begin
                        state_r    <= IDLE;
                        ld_time_r  <= 1'b0;
                        ld_alarm_r <= 1'b0;
                        stop_al_r  <= 1'b0;
                    end else begin
                        cnt_r      <= cnt_r + CW'(1'b1);
                        ld_time_r  <= (state_r == LOAD_T);
                        ld_alarm_r <= (state_r == LOAD_A);
                        stop_al_r  <= (state_r == STOP);
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    ld_time_r    <= 1'b0;
                    ld_alarm_r   <= 1'b0;
                    stop_al_r    <= 1'b0;
                    edit_field_r <= FIELD_NONE;
                end
            endcase
        end
    end

    assign H_in1      = h1_r;
    assign H_in0      = h0_r;
    assign M_in1      = m1_r;
    assign M_in0      = m0_r;
    assign LD_time    = ld_time_r;
    assign LD_alarm   = ld_alarm_r;
    assign AL_ON      = al_on_r;
    assign STOP_al    = stop_al_r;
    assign edit_field = edit_field_r;

endmodule

// File: tb/tb_aclock_setter.sv
// Directed bench for aclock_setter: a vector table of button presses with
// hand-computed results, plus sequences for strobes, wrap and reset cases.
module tb_aclock_setter;

    logic       clk = 1'b0;
    logic       reset, btn_mode, btn_inc, btn_set, Alarm;
    logic [1:0] H_out1;
    logic [3:0] H_out0, M_out1, M_out0;
    logic [1:0] H_in1;
    logic [3:0] H_in0, M_in1, M_in0;
    logic       LD_time, LD_alarm, AL_ON, STOP_al;
    logic [1:0] edit_field;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [5:0] hout;
        logic [7:0] mout;
        logic       al;
        logic       m, i, s;
        logic [1:0] ef;
        logic       alon;
        logic [5:0] h;
        logic [7:0] mn;
    } vec_t;

    vec_t tbl [0:32];

    always #5 clk = ~clk;

    aclock_setter #(.LOAD_HOLD(12)) dut (
        .clk(clk), .reset(reset),
        .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_set(btn_set),
        .H_out1(H_out1), .H_out0(H_out0), .M_out1(M_out1), .M_out0(M_out0),
        .Alarm(Alarm),
        .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
        .LD_time(LD_time), .LD_alarm(LD_alarm), .AL_ON(AL_ON), .STOP_al(STOP_al),
        .edit_field(edit_field)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One press: buttons high for one cycle, low afterwards; returns just
    // after the edge that acted on the press.
    task automatic press(input logic m, input logic i, input logic s);
        @(negedge clk);
        btn_mode = m; btn_inc = i; btn_set = s;
        @(negedge clk);
        btn_mode = 1'b0; btn_inc = 1'b0; btn_set = 1'b0;
    endtask

    // which: 0 LD_time, 1 LD_alarm, 2 STOP_al. An inc press mid-strobe must be ignored.
    task automatic measure(input string name, input int which, input logic [5:0] eh, input logic [7:0] em);
        int hi_cnt = 0;
        int other  = 0;
        int drift  = 0;
        logic sel;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            sel = (which == 0) ? LD_time : (which == 1) ? LD_alarm : STOP_al;
            if (sel) begin
                hi_cnt++;
                if ({H_in1, H_in0} !== eh || {M_in1, M_in0} !== em) drift++;
            end
            if ((which != 0 && LD_time) || (which != 1 && LD_alarm) || (which != 2 && STOP_al)) other++;
            if (c == 3) btn_inc = 1'b1;
            if (c == 4) btn_inc = 1'b0;
        end
        check({name, "_len"}, hi_cnt, 12);
        check({name, "_other"}, other, 0);
        check({name, "_stable"}, drift, 0);
    endtask

    task automatic quiet(input string name, input int cycles);
        int cnt = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (LD_time || LD_alarm || STOP_al) cnt++;
        end
        check(name, cnt, 0);
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int k = lo; k <= hi; k++) begin
            H_out1 = tbl[k].hout[5:4]; H_out0 = tbl[k].hout[3:0];
            M_out1 = tbl[k].mout[7:4]; M_out0 = tbl[k].mout[3:0];
            Alarm  = tbl[k].al;
            press(tbl[k].m, tbl[k].i, tbl[k].s);
            check($sformatf("vec%0d", k), {edit_field, AL_ON, H_in1, H_in0, M_in1, M_in0},
                  {tbl[k].ef, tbl[k].alon, tbl[k].h, tbl[k].mn});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //          hout   mout   al    m     i     s     ef    alon  h      mn
        tbl[0]  = '{6'h08, 8'h15, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 6'h08, 8'h15};
        tbl[1]  = '{6'h08, 8'h15, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 6'h09, 8'h15};
        tbl[2]  = '{6'h08, 8'h15, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 6'h10, 8'h15};
        tbl[3]  = '{6'h08, 8'h15, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 6'h11, 8'h15};
        tbl[4]  = '{6'h08, 8'h15, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 6'h11, 8'h15};
        tbl[5]  = '{6'h08, 8'h15, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 6'h11, 8'h16};
        tbl[6]  = '{6'h08, 8'h15, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 6'h11, 8'h17};
        tbl[7]  = '{6'h08, 8'h15, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 6'h11, 8'h17};
        tbl[8]  = '{6'h08, 8'h15, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 6'h11, 8'h17};
        tbl[9]  = '{6'h08, 8'h15, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 6'h08, 8'h15};
        tbl[10] = '{6'h08, 8'h15, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 6'h08, 8'h15};
        tbl[11] = '{6'h08, 8'h15, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 6'h08, 8'h15};
        tbl[12] = '{6'h08, 8'h15, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 6'h08, 8'h15};
        tbl[13] = '{6'h08, 8'h15, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 6'h00, 8'h00};
        tbl[14] = '{6'h08, 8'h15, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 6'h01, 8'h00};
        tbl[15] = '{6'h08, 8'h15, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 6'h01, 8'h00};
        tbl[16] = '{6'h25, 8'h61, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 6'h00, 8'h00};
        tbl[17] = '{6'h25, 8'h61, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 6'h00, 8'h00};
        tbl[18] = '{6'h23, 8'h59, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 6'h23, 8'h59};
        tbl[19] = '{6'h23, 8'h59, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 6'h00, 8'h59};
        tbl[20] = '{6'h23, 8'h59, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 6'h00, 8'h59};
        tbl[21] = '{6'h23, 8'h59, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 6'h00, 8'h00};
        tbl[22] = '{6'h23, 8'h59, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 6'h00, 8'h00};
        tbl[23] = '{6'h19, 8'h09, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 6'h19, 8'h09};
        tbl[24] = '{6'h19, 8'h09, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 6'h20, 8'h09};
        tbl[25] = '{6'h19, 8'h09, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 6'h20, 8'h09};
        tbl[26] = '{6'h19, 8'h09, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 6'h20, 8'h10};
        tbl[27] = '{6'h19, 8'h09, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 6'h20, 8'h10};
        tbl[28] = '{6'h0A, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 6'h00, 8'h00};
        tbl[29] = '{6'h0A, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 6'h00, 8'h00};
        tbl[30] = '{6'h0A, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 6'h00, 8'h00};
        tbl[31] = '{6'h0A, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 6'h01, 8'h00};
        tbl[32] = '{6'h0A, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 6'h01, 8'h00};

        reset = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0; btn_set = 1'b0; Alarm = 1'b0;
        H_out1 = 2'd0; H_out0 = 4'd8; M_out1 = 4'd1; M_out0 = 4'd5;
        repeat (3) @(negedge clk);
        check("reset_outputs", {H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm, AL_ON, STOP_al, edit_field}, 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Set time 08:15 -> 11:17 and load it
        run_vecs(0, 7);
        measure("ld_time", 0, 6'h11, 8'h17);
        check("ld_time_done", {LD_time, edit_field}, 3'd0);

        // Alarm enable toggle, simultaneous mode+inc, cancel from T_MIN
        run_vecs(8, 11);
        quiet("cancel_no_strobe", 20);
        run_vecs(12, 13);

        // Alarm edit: hour wrap, minute wrap, load alarm 01:00
        for (int k = 0; k < 23; k++) press(1'b0, 1'b1, 1'b0);
        check("alarm_hour_23", {H_in1, H_in0}, 6'h23);
        press(1'b0, 1'b1, 1'b0);
        check("alarm_hour_wrap", {H_in1, H_in0}, 6'h00);
        press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        check("alarm_min_field", {edit_field, H_in1, H_in0, M_in1, M_in0}, {2'd2, 6'h01, 8'h00});
        for (int k = 0; k < 59; k++) press(1'b0, 1'b1, 1'b0);
        check("alarm_min_59", {H_in1, H_in0, M_in1, M_in0}, {6'h01, 8'h59});
        press(1'b0, 1'b1, 1'b0);
        check("alarm_min_wrap", {H_in1, H_in0, M_in1, M_in0}, {6'h01, 8'h00});
        press(1'b1, 1'b0, 1'b0);
        measure("ld_alarm", 1, 6'h01, 8'h00);

        // Stored alarm recall, clamping, BCD carries, alarm stop
        run_vecs(14, 30);
        measure("stop_al", 2, 6'h00, 8'h00);
        run_vecs(31, 32);

        // Reset on the fifth cycle of the LD_alarm strobe
        begin
            int seen = 0;
            int guard = 0;
            press(1'b0, 1'b0, 1'b1);
            press(1'b1, 1'b0, 1'b0);
            press(1'b1, 1'b0, 1'b0);
            while (seen < 5 && guard < 40) begin
                @(negedge clk);
                guard++;
                if (LD_alarm) seen++;
            end
            check("ld_alarm_reached5", seen, 5);
            reset = 1'b0;
            @(negedge clk);
            check("midstrobe_reset", {H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm, AL_ON, STOP_al, edit_field}, 32'd0);
            reset = 1'b1;
            quiet("no_resume", 20);
            press(1'b0, 1'b0, 1'b1);
            check("alarm_cleared", {edit_field, H_in1, H_in0, M_in1, M_in0}, {2'd1, 6'h00, 8'h00});
            press(1'b0, 1'b0, 1'b1);
        end

        // inc held for 50 cycles toggles AL_ON once
        @(negedge clk);
        btn_inc = 1'b1;
        repeat (50) @(negedge clk);
        btn_inc = 1'b0;
        @(negedge clk);
        check("held_inc_once", AL_ON, 1'b1);

        // mode held across reset release must not start an edit
        btn_mode = 1'b1;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("held_mode_reset", {edit_field, AL_ON}, 3'd0);
        btn_mode = 1'b0;
        repeat (2) @(negedge clk);
        check("release_no_edge", edit_field, 2'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/aclock_setter.md
ACLOCK_SETTER -- requirements
Module: aclock_setter

Interface
REQ-001 Parameter LOAD_HOLD, default 12: cycles LD_time/LD_alarm/STOP_al are held high (must exceed one 1 s tick period of the clock core, 10 clk).
REQ-002 clk  in  1  system clock, all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-low reset.
REQ-004 btn_mode  in  1  mode/advance button, debounced level, synchronous to clk.
REQ-005 btn_inc  in  1  increment button, debounced level.
REQ-006 btn_set  in  1  alarm-edit / cancel / stop button, debounced level.
REQ-007 H_out1 in 2, H_out0 in 4, M_out1 in 4, M_out0 in 4: current BCD time from the clock core.
REQ-008 Alarm  in  1  alarm-ringing indication from the clock core.
REQ-009 H_in1 out 2, H_in0 out 4, M_in1 out 4, M_in0 out 4: BCD time/alarm value presented to the clock core.
REQ-010 LD_time  out  1  load-time strobe; LD_alarm  out  1  load-alarm strobe.
REQ-011 AL_ON  out  1  alarm enable level; STOP_al  out  1  alarm-stop strobe.
REQ-012 edit_field  out  2  0 none, 1 hours, 2 minutes (display blink select).

Function
REQ-013 Each button SHALL be registered once and acted on only at its rising edge (one action per press, holding has no effect).
REQ-014 Same-cycle edges SHALL be prioritised set > mode > inc; lower-priority edges in that cycle are discarded.
REQ-015 States SHALL be IDLE, T_HOUR, T_MIN, A_HOUR, A_MIN, LOAD_T, LOAD_A, STOP.
REQ-016 IDLE: mode edge -> T_HOUR, edit register preloaded with H_out*/M_out* of that cycle.
REQ-017 IDLE: set edge with Alarm=1 -> STOP; set edge with Alarm=0 -> A_HOUR, edit register preloaded from stored alarm value.
REQ-018 IDLE: inc edge SHALL toggle AL_ON.
REQ-019 T_HOUR/A_HOUR: inc edge increments hours 00..23, 23 wraps to 00; mode edge -> T_MIN/A_MIN.
REQ-020 T_MIN/A_MIN: inc edge increments minutes 00..59, 59 wraps to 00, hours unchanged; mode edge -> LOAD_T/LOAD_A.
REQ-021 set edge in any edit state SHALL cancel: -> IDLE, no strobe, stored alarm unchanged.
REQ-022 Hour and minute SHALL be held as BCD digit pairs; increment carries low digit 9 -> 0 into high digit; no binary conversion.
REQ-023 LOAD_T: LD_time high exactly LOAD_HOLD cycles starting the cycle after entry, then -> IDLE; LOAD_A likewise with LD_alarm, and stored alarm updated on entry.
REQ-024 STOP: STOP_al high exactly LOAD_HOLD cycles, then -> IDLE.
REQ-025 H_in*/M_in* SHALL show the edit register in edit and load states and remain stable throughout every strobe; in IDLE/STOP they hold last value.
REQ-026 Button edges during LOAD_T, LOAD_A, STOP SHALL be ignored.
REQ-027 At most one of LD_time, LD_alarm, STOP_al SHALL be high in any cycle.
REQ-028 edit_field SHALL be 1 in T_HOUR/A_HOUR, 2 in T_MIN/A_MIN, 0 otherwise, decoded from state registers (glitch-free).
REQ-029 Out-of-range preload (hours >23 or minutes >59) SHALL be clamped to 00 for that field.

Reset
REQ-030 reset=0 at a clk edge SHALL force IDLE, all outputs 0 (H_in*, M_in*, LD_time, LD_alarm, AL_ON, STOP_al, edit_field), stored alarm 00:00, hold counter 0, button history 0.
REQ-031 Reset mid-strobe SHALL drop the strobe the next cycle with no later resumption.
REQ-032 A button already high when reset releases SHALL NOT produce an edge.

Structure
REQ-033 Shared package SHALL hold the state enum, field codes (NONE/HOUR/MIN) and max constants 23, 59.
REQ-034 One sub-module, bcd_wrap_inc (BCD pair + programmable max -> incremented pair with wrap), SHALL serve hours and minutes.

Verification
REQ-035 Clock shows 08:15; mode, inc x3, mode, inc x2, mode -> LD_time high 12 cycles with H_in=1,1 M_in=1,7 (11:17).
REQ-036 Alarm edit from 00:00: set, inc x23 -> hours 23; inc once more -> 00; minutes 59 + inc -> 00, hours unchanged.
REQ-037 Alarm=1, set edge in IDLE -> STOP_al 12 cycles, LD_alarm stays 0, state returns IDLE.
REQ-038 mode and inc edges same cycle in IDLE -> enters T_HOUR, AL_ON unchanged; set during T_MIN -> IDLE, no strobe.
REQ-039 Reset low at cycle 5 of LD_alarm strobe -> all outputs 0 next cycle, stored alarm 00:00.
REQ-040 btn_inc held high 50 cycles in IDLE -> AL_ON toggles exactly once.
